// File: rtl/alarm_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_set_ctrl_if
//  Purpose  : Button-side and setter-side signal bundle for alarm_set_ctrl.
//             The master drives the synchronized buttons and TICK, and the
//             slave (the sequencer) returns the field select, the increment
//             strobe and the editing flag.
//  Revision : 1.0 - initial release
// ============================================================================
interface alarm_set_ctrl_if;
  logic       tick;
  logic       mode_btn;
  logic       inc_btn;
  logic [1:0] order;
  logic       increment;
  logic       editing;

  modport master (
    output tick,
    output mode_btn,
    output inc_btn,
    input  order,
    input  increment,
    input  editing
  );

  modport slave (
    input  tick,
    input  mode_btn,
    input  inc_btn,
    output order,
    output increment,
    output editing
  );
endinterface
`default_nettype wire

// File: rtl/alarm_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_set_ctrl
//  Purpose  : Front-panel sequencer for the alarm-time setter. MODE steps
//             through seconds/minutes/hours, INC issues one increment per
//             press with auto-repeat while held, and editing is abandoned
//             after a period of inactivity.
//  Revision : 1.0 - initial release
// ============================================================================
module alarm_set_ctrl #(
  parameter int REPEAT_DELAY  = 4,
  parameter int REPEAT_PERIOD = 2,
  parameter int TIMEOUT       = 10
) (
  input  wire              clk,
  input  wire              RESET,
  alarm_set_ctrl_if.slave  bus
);

  localparam logic [7:0] c_delay   = 8'(REPEAT_DELAY);
  localparam logic [7:0] c_period  = 8'(REPEAT_PERIOD);
  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  localparam logic [1:0] c_ord_sec  = 2'b00;
  localparam logic [1:0] c_ord_min  = 2'b01;
  localparam logic [1:0] c_ord_hour = 2'b10;
  localparam logic [1:0] c_ord_none = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SET_SEC  = 2'd1,
    S_SET_MIN  = 2'd2,
    S_SET_HOUR = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_mode_q;
  logic       r_inc_q;
  logic [7:0] r_rpt_cnt;
  logic       r_rpt_first;
  logic [7:0] r_idle_cnt;

  logic       w_mode_press;
  logic       w_inc_press;
  logic [7:0] w_rpt_inc;
  logic [7:0] w_idle_inc;
  logic       w_rpt_hit;
  logic       w_timeout;

  // Rising-edge detection against last cycle's button levels, plus the
  // next-count values and match conditions for the two timers.
  assign w_mode_press = bus.mode_btn & ~r_mode_q;
  assign w_inc_press  = bus.inc_btn  & ~r_inc_q;
  assign w_rpt_inc    = r_rpt_cnt  + 8'd1;
  assign w_idle_inc   = r_idle_cnt + 8'd1;
  // The first repeat waits the longer delay; later ones use the period.
  assign w_rpt_hit    = r_rpt_first ? (w_rpt_inc == c_period)
                                    : (w_rpt_inc == c_delay);
  assign w_timeout    = (r_state != S_IDLE) & ~bus.inc_btn & bus.tick &
                        (w_idle_inc == c_timeout);

  // Sequencer: field state, registered outputs, repeat and inactivity timers.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      r_state       <= S_IDLE;
      r_mode_q      <= 1'b0;
      r_inc_q       <= 1'b0;
      r_rpt_cnt     <= 8'd0;
      r_rpt_first   <= 1'b0;
      r_idle_cnt    <= 8'd0;
      bus.order     <= c_ord_none;
      bus.increment <= 1'b0;
      bus.editing   <= 1'b0;
    end else begin
      r_mode_q      <= bus.mode_btn;
      r_inc_q       <= bus.inc_btn;
      bus.increment <= 1'b0;

      if (r_state == S_IDLE) begin
        // INC is ignored here; only MODE opens an editing session.
        r_rpt_cnt   <= 8'd0;
        r_rpt_first <= 1'b0;
        r_idle_cnt  <= 8'd0;
        if (w_mode_press) begin
          r_state     <= S_SET_SEC;
          bus.order   <= c_ord_sec;
          bus.editing <= 1'b1;
        end
      end else if (w_mode_press) begin
        // MODE outranks INC, repeat pulses and timeout; no strobe this cycle
        // so ORDER never moves together with INCREMENT.
        r_rpt_cnt   <= 8'd0;
        r_rpt_first <= 1'b0;
        r_idle_cnt  <= 8'd0;
        case (r_state)
          S_SET_SEC: begin
            r_state   <= S_SET_MIN;
            bus.order <= c_ord_min;
          end
          S_SET_MIN: begin
            r_state   <= S_SET_HOUR;
            bus.order <= c_ord_hour;
          end
          default: begin
            r_state     <= S_IDLE;
            bus.order   <= c_ord_none;
            bus.editing <= 1'b0;
          end
        endcase
      end else if (w_timeout) begin
        r_state     <= S_IDLE;
        bus.order   <= c_ord_none;
        bus.editing <= 1'b0;
        r_rpt_cnt   <= 8'd0;
        r_rpt_first <= 1'b0;
        r_idle_cnt  <= 8'd0;
      end else begin
        // Inactivity counts only TICKs with INC released.
        if (bus.inc_btn) begin
          r_idle_cnt <= 8'd0;
        end else if (bus.tick) begin
          r_idle_cnt <= w_idle_inc;
        end

        if (w_inc_press) begin
          bus.increment <= 1'b1;
          r_rpt_cnt     <= 8'd0;
          r_rpt_first   <= 1'b0;
        end else if (!bus.inc_btn) begin
          r_rpt_cnt   <= 8'd0;
          r_rpt_first <= 1'b0;
        end else if (bus.tick) begin
          if (w_rpt_hit) begin
            bus.increment <= 1'b1;
            r_rpt_cnt     <= 8'd0;
            r_rpt_first   <= 1'b1;
          end else begin
            r_rpt_cnt <= w_rpt_inc;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
